// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - per-pixel object compositor with shadow/active object tables
// Three-stage pipeline: coordinate deltas, per-object coverage, priority select.
module sprite_compositor #(
  parameter int          NUM_OBJ = 4,
  parameter int          COORD_W = 10,
  parameter int          SIZE_W  = 10,
  parameter logic [23:0] BG_RGB  = 24'h00AA00,
  localparam int         IDX_W   = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_sync,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [SIZE_W-1:0]  wr_size,
  input  logic               wr_shape,
  input  logic               wr_enable,
  input  logic [23:0]        wr_rgb,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic               out_valid,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue,
  output logic               hit,
  output logic [IDX_W-1:0]   hit_idx
);
  localparam int D_W  = COORD_W + 1;
  localparam int SQ_W = 2 * D_W + 1;

  typedef struct packed {
    logic               en;
    logic               shape;
    logic [SIZE_W-1:0]  size;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [23:0]        rgb;
  } obj_t;

  obj_t shadow_q [NUM_OBJ];
  obj_t shadow_d [NUM_OBJ];
  obj_t active_q [NUM_OBJ];
  obj_t active_d [NUM_OBJ];

  logic                  v1_q, v1_d;
  logic signed [D_W-1:0] dx1_q [NUM_OBJ];
  logic signed [D_W-1:0] dx1_d [NUM_OBJ];
  logic signed [D_W-1:0] dy1_q [NUM_OBJ];
  logic signed [D_W-1:0] dy1_d [NUM_OBJ];
  logic [SIZE_W-1:0]     size1_q [NUM_OBJ];
  logic [SIZE_W-1:0]     size1_d [NUM_OBJ];
  logic [NUM_OBJ-1:0]    shape1_q, shape1_d, en1_q, en1_d;
  logic [23:0]           rgb1_q [NUM_OBJ];
  logic [23:0]           rgb1_d [NUM_OBJ];

  logic                  v2_q, v2_d;
  logic [NUM_OBJ-1:0]    cov2_q, cov2_d;
  logic [23:0]           rgb2_q [NUM_OBJ];
  logic [23:0]           rgb2_d [NUM_OBJ];

  logic                  out_valid_q, out_valid_d;
  logic [23:0]           rgb_q, rgb_d;
  logic                  hit_q, hit_d;
  logic [IDX_W-1:0]      hit_idx_q, hit_idx_d;

  // Commit copies the pre-write shadow, so a same-cycle write waits for the next frame_sync.
  always_comb begin
    for (int i = 0; i < NUM_OBJ; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = frame_sync ? shadow_q[i] : active_q[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        shadow_d[i] = '{en: wr_enable, shape: wr_shape, size: wr_size,
                        x: wr_x, y: wr_y, rgb: wr_rgb};
      end
    end
  end

  always_comb begin
    v1_d = pix_valid;
    for (int i = 0; i < NUM_OBJ; i++) begin
      dx1_d[i]    = $signed({1'b0, DrawX}) - $signed({1'b0, active_q[i].x});
      dy1_d[i]    = $signed({1'b0, DrawY}) - $signed({1'b0, active_q[i].y});
      size1_d[i]  = active_q[i].size;
      shape1_d[i] = active_q[i].shape;
      en1_d[i]    = active_q[i].en;
      rgb1_d[i]   = active_q[i].rgb;
    end
  end

  logic [D_W-1:0]  adx, ady;
  logic [SQ_W-1:0] ax, ay, sz;
  always_comb begin
    v2_d   = v1_q;
    cov2_d = '0;
    adx    = '0;
    ady    = '0;
    ax     = '0;
    ay     = '0;
    sz     = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      adx       = dx1_q[i][D_W-1] ? $unsigned(-dx1_q[i]) : $unsigned(dx1_q[i]);
      ady       = dy1_q[i][D_W-1] ? $unsigned(-dy1_q[i]) : $unsigned(dy1_q[i]);
      ax        = SQ_W'(adx);
      ay        = SQ_W'(ady);
      sz        = SQ_W'(size1_q[i]);
      cov2_d[i] = en1_q[i] && (shape1_q[i] ? ((ax * ax + ay * ay) <= sz * sz)
                                            : ((ax <= sz) && (ay <= sz)));
      rgb2_d[i] = rgb1_q[i];
    end
  end

  always_comb begin
    out_valid_d = v2_q;
    rgb_d       = rgb_q;
    hit_d       = hit_q;
    hit_idx_d   = hit_idx_q;
    if (v2_q) begin
      rgb_d     = BG_RGB;
      hit_d     = 1'b0;
      hit_idx_d = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--) begin
        if (cov2_q[i]) begin
          rgb_d     = rgb2_q[i];
          hit_d     = 1'b1;
          hit_idx_d = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        dx1_q[i]    <= '0;
        dy1_q[i]    <= '0;
        size1_q[i]  <= '0;
        rgb1_q[i]   <= '0;
        rgb2_q[i]   <= '0;
      end
      v1_q        <= 1'b0;
      shape1_q    <= '0;
      en1_q       <= '0;
      v2_q        <= 1'b0;
      cov2_q      <= '0;
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
        dx1_q[i]    <= dx1_d[i];
        dy1_q[i]    <= dy1_d[i];
        size1_q[i]  <= size1_d[i];
        rgb1_q[i]   <= rgb1_d[i];
        rgb2_q[i]   <= rgb2_d[i];
      end
      v1_q        <= v1_d;
      shape1_q    <= shape1_d;
      en1_q       <= en1_d;
      v2_q        <= v2_d;
      cov2_q      <= cov2_d;
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Red       = rgb_q[23:16];
  assign Green     = rgb_q[15:8];
  assign Blue      = rgb_q[7:0];
  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - scoreboard bench for sprite_compositor
// Expected pixels come from a geometric model of the object tables and drain through a queue.
module tb_sprite_compositor;
  localparam logic [23:0] BG = 24'h00AA00;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        frame_sync = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_idx = '0;
  logic [9:0]  wr_x = '0, wr_y = '0, wr_size = '0;
  logic        wr_shape = 1'b0, wr_enable = 1'b0;
  logic [23:0] wr_rgb = '0;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        out_valid;
  logic [7:0]  Red, Green, Blue;
  logic        hit;
  logic [1:0]  hit_idx;

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_sync(frame_sync), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_x(wr_x), .wr_y(wr_y), .wr_size(wr_size), .wr_shape(wr_shape), .wr_enable(wr_enable),
    .wr_rgb(wr_rgb), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
    .out_valid(out_valid), .Red(Red), .Green(Green), .Blue(Blue), .hit(hit), .hit_idx(hit_idx)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int          x, y, size;
    bit          shape, en;
    logic [23:0] rgb;
  } mobj_t;

  typedef struct {
    logic [23:0] rgb;
    bit          hit;
    int          idx;
    int          due;
  } exp_t;

  mobj_t m_sh [4];
  mobj_t m_act [4];
  exp_t  q [$];
  exp_t  last_e;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit covers(mobj_t o, int px, int py);
    int dx, dy, ax, ay;
    if (!o.en) return 1'b0;
    dx = px - o.x;
    dy = py - o.y;
    ax = (dx < 0) ? -dx : dx;
    ay = (dy < 0) ? -dy : dy;
    if (o.shape) return (dx * dx + dy * dy) <= o.size * o.size;
    return (ax <= o.size) && (ay <= o.size);
  endfunction

  function automatic exp_t model_pix(int px, int py, int due);
    exp_t e;
    e.rgb = BG; e.hit = 1'b0; e.idx = 0; e.due = due;
    for (int i = 0; i < 4; i++) begin
      if (!e.hit && covers(m_act[i], px, py)) begin
        e.hit = 1'b1; e.idx = i; e.rgb = m_act[i].rgb;
      end
    end
    return e;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      m_sh[i]  = '{x: 0, y: 0, size: 0, shape: 1'b0, en: 1'b0, rgb: 24'h0};
      m_act[i] = m_sh[i];
    end
    last_e = '{rgb: 24'h0, hit: 1'b0, idx: 0, due: 0};
  endtask

  task automatic step();
    if (pix_valid) q.push_back(model_pix(int'(DrawX), int'(DrawY), cyc + 3));
    @(posedge Clk);
    if (frame_sync) m_act = m_sh;
    if (wr_en) begin
      m_sh[wr_idx].x     = int'(wr_x);
      m_sh[wr_idx].y     = int'(wr_y);
      m_sh[wr_idx].size  = int'(wr_size);
      m_sh[wr_idx].shape = wr_shape;
      m_sh[wr_idx].en    = wr_enable;
      m_sh[wr_idx].rgb   = wr_rgb;
    end
    #1;
    frame_sync = 1'b0;
    wr_en      = 1'b0;
    pix_valid  = 1'b0;
  endtask

  task automatic set_wr(input int idx, input int x, input int y, input int sz,
                        input bit sh, input bit en, input logic [23:0] rgb);
    wr_en = 1'b1; wr_idx = idx[1:0]; wr_x = x[9:0]; wr_y = y[9:0]; wr_size = sz[9:0];
    wr_shape = sh; wr_enable = en; wr_rgb = rgb;
  endtask

  task automatic set_pix(input int x, input int y);
    pix_valid = 1'b1; DrawX = x[9:0]; DrawY = y[9:0];
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " rgb"}, {Red, Green, Blue}, 0);
    chk({tag, " hit"}, hit, 0);
    chk({tag, " hit_idx"}, hit_idx, 0);
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected out_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency", cyc, e.due);
          chk("rgb", {Red, Green, Blue}, e.rgb);
          chk("hit", hit, e.hit);
          chk("hit_idx", hit_idx, e.idx);
          last_e = e;
        end
      end else begin
        chk("hold rgb", {Red, Green, Blue}, last_e.rgb);
        chk("hold hit", hit, last_e.hit);
        chk("hold hit_idx", hit_idx, last_e.idx);
      end
    end
  end

  function automatic int rnd_coord();
    case ($urandom_range(0, 2))
      0:       return $urandom_range(0, 12);
      1:       return $urandom_range(1011, 1023);
      default: return $urandom_range(0, 1023);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    clear_model();
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    Reset = 1'b1;

    // Empty table: background.
    frame_sync = 1'b1; step();
    set_pix(100, 100); step();

    // Shadow write is invisible until committed.
    set_wr(1, 100, 100, 5, 1'b0, 1'b1, 24'hFF0000); step();
    set_pix(105, 95); step();
    frame_sync = 1'b1; step();
    set_pix(105, 95); step();
    set_pix(106, 95); step();

    // Overlap resolved by index; circle edge.
    set_wr(0, 200, 200, 10, 1'b1, 1'b1, 24'h0000FF); step();
    set_wr(1, 200, 200, 10, 1'b0, 1'b1, 24'hFF0000); step();
    frame_sync = 1'b1; step();
    set_pix(207, 207); step();
    set_pix(208, 208); step();
    set_pix(210, 200); step();

    // Screen-edge clipping, size 0, far corner.
    set_wr(0, 2, 2, 5, 1'b0, 1'b1, 24'hFFFFFF); step();
    set_wr(2, 500, 500, 0, 1'b1, 1'b1, 24'h123456); step();
    set_wr(3, 1021, 1021, 5, 1'b0, 1'b1, 24'h654321); step();
    frame_sync = 1'b1; step();
    set_pix(1020, 1020); step();
    set_pix(0, 0); step();
    set_pix(500, 500); step();
    set_pix(501, 500); step();
    set_pix(1023, 1023); step();
    set_pix(2, 1023); step();

    // Write and pixel in the commit cycle, then back-to-back commits.
    set_wr(0, 2, 2, 5, 1'b0, 1'b1, 24'h00FF00);
    frame_sync = 1'b1; set_pix(2, 2); step();
    set_pix(2, 2); step();
    frame_sync = 1'b1; step();
    frame_sync = 1'b1; set_pix(2, 2); step();
    set_pix(2, 2); step();
    repeat (4) step();

    // Reset mid-stream.
    for (int k = 0; k < 5; k++) begin
      set_pix(2 + k, 2); step();
    end
    Reset = 1'b0;
    q.delete();
    clear_model();
    #1;
    check_reset_outputs("mid-stream reset");
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_pix(2 + k, 2); step();
    end
    frame_sync = 1'b1; set_pix(1021, 1021); step();
    set_pix(1021, 1021); step();

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        set_wr($urandom_range(0, 3), rnd_coord(), rnd_coord(),
               ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 24),
               1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
               24'($urandom()));
      end
      if ($urandom_range(0, 11) == 0) frame_sync = 1'b1;
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) == 0) begin
          int j;
          j = $urandom_range(0, 3);
          set_pix((m_act[j].x + $urandom_range(0, 50) - 25 + 1024) % 1024,
                  (m_act[j].y + $urandom_range(0, 50) - 25 + 1024) % 1024);
        end else begin
          set_pix(rnd_coord(), rnd_coord());
        end
      end
      step();
    end

    for (int k = 0; k < 10; k++) begin
      if (q.size() == 0) break;
      @(posedge Clk);
    end
    #1;
    chk("drain", q.size(), 0);
    @(negedge Clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
